seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values 8 to 64.
REQ-002 Parameter MEM_LIMIT, default 255: highest legal data-memory byte address.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request; accepted only while busy=0.
REQ-006 ALUop  input  4  operation select; encoding in REQ-013.
REQ-007 op1, op2  input  WIDTH each  signed operands; sampled at accept.
REQ-008 shamt  input  $clog2(WIDTH)  shift amount; sampled at accept.
REQ-009 busy  output  1  high from the cycle after accept until the cycle done is high, inclusive.
REQ-010 done  output  1  one-cycle pulse; registered outputs are valid from this cycle.
REQ-011 result  output  WIDTH  registered result.
REQ-012 OVF, zero, memory_out_of_bound  output  1 each  registered status flags.

Function
REQ-013 ALUop encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 nor, 0110 slt, 0111 sll op2, 1000 srl op2, 1001 sgt, 1010 mul, 1011 div, 1100 rem, 1101 sra op2; 1110 and 1111 give result 0.
REQ-014 States: IDLE, MUL, DIV, FIN. Reset state is IDLE.
REQ-015 Accept means start=1 while in IDLE; operands, ALUop and shamt are latched at accept.
REQ-016 A start that arrives in any state other than IDLE is ignored and is not queued.
REQ-017 For single-cycle ops (everything except 1010, 1011, 1100), the block goes IDLE->FIN, and done=1 exactly one cycle after accept.
REQ-018 For mul, the block goes IDLE->MUL and runs WIDTH iterations of shift-add, one per cycle. It then goes MUL->FIN, so done=1 exactly WIDTH+1 cycles after accept.
REQ-019 For div and rem, the block goes IDLE->DIV and runs WIDTH iterations of restoring division on operand magnitudes. It then goes DIV->FIN and applies the signs: quotient negative when operand signs differ, remainder takes op1's sign. done=1 exactly WIDTH+1 cycles after accept.
REQ-020 FIN lasts one cycle, asserts done, and then goes to IDLE; a new start may be accepted in the cycle after FIN.
REQ-021 result, OVF, zero and memory_out_of_bound update only in the FIN cycle and hold until the next FIN.
REQ-022 mul result is the low WIDTH bits of the signed 2·WIDTH-bit product.
REQ-023 OVF for add: set when the operands have the same sign and the result sign differs.
REQ-024 OVF for sub: set when the operands have differing signs and the result sign differs from op1.
REQ-025 OVF for mul: set when the full signed product does not fit in WIDTH bits.
REQ-026 OVF for all other ops: 0, except as given in REQ-027 and REQ-028.
REQ-027 Divide by zero: div result is all ones, rem result is op1, OVF=1.
REQ-028 Signed overflow (op1 = most-negative, op2 = -1): div result is op1, rem result is 0, OVF=1.
REQ-029 zero=1 exactly when the committed result is 0.
REQ-030 memory_out_of_bound is evaluated for every op. It is set when the (WIDTH+1)-bit signed sum op1+op2 is below 0 or above MEM_LIMIT.
REQ-031 Shifts use the latched shamt. srl and sll fill with zeros; sra replicates op2's MSB.
REQ-032 slt and sgt compare signed and return 1 or 0, zero-extended to WIDTH.

Reset
REQ-033 While rst=0: state=IDLE, and busy, done, result, OVF, zero and memory_out_of_bound are all 0.
REQ-034 Reset asserted mid-operation aborts it: no done pulse follows and the partial result is discarded.
REQ-035 The first start may be accepted on the first rising clk edge with rst=1.

Verification
REQ-036 WIDTH=32, add op1=0x7FFFFFFF, op2=1 -> one cycle later done=1, result=0x80000000, OVF=1, zero=0, memory_out_of_bound=1.
REQ-037 WIDTH=32, mul op1=-3, op2=7 -> done exactly 33 cycles after accept, result=-21, OVF=0, busy=1 throughout; a start pulsed at cycle 5 is ignored.
REQ-038 WIDTH=32, div op1=-7, op2=2 -> result=-3; rem with the same operands -> result=-1. Div op1=5, op2=0 -> result=0xFFFFFFFF, OVF=1.
REQ-039 WIDTH=8, div op1=0x80, op2=0xFF -> result=0x80, OVF=1. sra op2=0x90, shamt=3 -> result=0xF2.
REQ-040 WIDTH=32, add op1=200, op2=55 -> memory_out_of_bound=0; op2=56 -> memory_out_of_bound=1; op1=-1, op2=0 -> memory_out_of_bound=1.
REQ-041 Reset asserted 10 cycles into a mul -> all outputs 0 immediately, no done. After release, sub 5-5 -> done one cycle after accept, result=0, zero=1.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential signed ALU: single-cycle logic/arith ops, shift-add multiply and
// restoring divide, with registered result and status flags committed on FIN.
module seq_alu #(
   parameter int WIDTH     = 32,
   parameter int MEM_LIMIT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [3:0]               ALUop,
   input  logic [WIDTH-1:0]         op1,
   input  logic [WIDTH-1:0]         op2,
   input  logic [$clog2(WIDTH)-1:0] shamt,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH-1:0]         result,
   output logic                     OVF,
   output logic                     zero,
   output logic                     memory_out_of_bound,
   output logic [1:0]               dbg_state_o
);

   localparam int               CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH:0]   MEM_LIM   = (WIDTH+1)'(MEM_LIMIT);
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOR = 4'b0101;
   localparam logic [3:0] OP_SLT = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b0111;
   localparam logic [3:0] OP_SRL = 4'b1000;
   localparam logic [3:0] OP_SGT = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;
   localparam logic [3:0] OP_DIV = 4'b1011;
   localparam logic [3:0] OP_REM = 4'b1100;
   localparam logic [3:0] OP_SRA = 4'b1101;

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   state_t             state_q, state_d;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q, mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
   logic [WIDTH-1:0]   result_q;
   logic               ovf_q, zero_q, mob_q;

   logic [WIDTH-1:0]   add_w, sub_w, sc_res;
   logic               sc_ovf;
   logic [WIDTH-1:0]   mem_a, mem_b;
   logic [WIDTH:0]     msum;
   logic               mob_d;
   logic [2*WIDTH-1:0] acc_n, prod;
   logic               mul_ovf;
   logic [WIDTH:0]     rsh, diff;
   logic               ge;
   logic [WIDTH-1:0]   rem_n, quo_n, q_s, r_s;
   logic               commit;
   logic [WIDTH-1:0]   res_d;
   logic               ovf_d;

   // Single-cycle ops are evaluated straight from the ports at accept.
   always_comb begin
      add_w  = op1 + op2;
      sub_w  = op1 - op2;
      sc_res = '0;
      sc_ovf = 1'b0;
      case (ALUop)
         OP_ADD: begin
            sc_res = add_w;
            sc_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_w[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = sub_w;
            sc_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_w[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_AND:  sc_res = op1 & op2;
         OP_OR:   sc_res = op1 | op2;
         OP_XOR:  sc_res = op1 ^ op2;
         OP_NOR:  sc_res = ~(op1 | op2);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
         OP_SGT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(op1) > $signed(op2))};
         OP_SLL:  sc_res = op2 << shamt;
         OP_SRL:  sc_res = op2 >> shamt;
         OP_SRA:  sc_res = $signed(op2) >>> shamt;
         default: sc_res = '0;
      endcase
   end

   always_comb begin
      mem_a = (state_q == IDLE) ? op1 : a_q;
      mem_b = (state_q == IDLE) ? op2 : b_q;
      msum  = {mem_a[WIDTH-1], mem_a} + {mem_b[WIDTH-1], mem_b};
      mob_d = msum[WIDTH] | (msum > MEM_LIM);
   end

   // Multiply and divide run on magnitudes; signs are restored at commit.
   always_comb begin
      acc_n   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      prod    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc_n : acc_n;
      mul_ovf = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
      rsh     = {rem_q, quo_q[WIDTH-1]};
      diff    = rsh - {1'b0, dvsr_q};
      ge      = ~diff[WIDTH];
      rem_n   = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
      quo_n   = {quo_q[WIDTH-2:0], ge};
      q_s     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_n : quo_n;
      r_s     = a_q[WIDTH-1] ? -rem_n : rem_n;
   end

   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      res_d   = sc_res;
      ovf_d   = sc_ovf;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (ALUop == OP_MUL) begin
                  state_d = MUL;
               end else if (ALUop == OP_DIV || ALUop == OP_REM) begin
                  state_d = DIV;
               end else begin
                  state_d = FIN;
                  commit  = 1'b1;
               end
            end
         end
         MUL: begin
            if (cnt_q == LAST_ITER) begin
               state_d = FIN;
               commit  = 1'b1;
               res_d   = prod[WIDTH-1:0];
               ovf_d   = mul_ovf;
            end
         end
         DIV: begin
            if (cnt_q == LAST_ITER) begin
               state_d = FIN;
               commit  = 1'b1;
               if (b_q == '0) begin
                  res_d = (op_q == OP_DIV) ? '1 : a_q;
                  ovf_d = 1'b1;
               end else if (a_q == MOST_NEG && b_q == '1) begin
                  res_d = (op_q == OP_DIV) ? a_q : '0;
                  ovf_d = 1'b1;
               end else begin
                  res_d = (op_q == OP_DIV) ? q_s : r_s;
                  ovf_d = 1'b0;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         mob_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            op_q     <= ALUop;
            a_q      <= op1;
            b_q      <= op2;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mag(op1)};
            mplier_q <= mag(op2);
            rem_q    <= '0;
            quo_q    <= mag(op1);
            dvsr_q   <= mag(op2);
         end else if (state_q == MUL) begin
            acc_q    <= acc_n;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
         end else if (state_q == DIV) begin
            rem_q    <= rem_n;
            quo_q    <= quo_n;
            cnt_q    <= cnt_q + CW'(1);
         end
         if (commit) begin
            result_q <= res_d;
            ovf_q    <= ovf_d;
            zero_q   <= (res_d == '0);
            mob_q    <= mob_d;
         end
      end
   end

   assign busy                = (state_q != IDLE);
   assign done                = (state_q == FIN);
   assign result              = result_q;
   assign OVF                 = ovf_q;
   assign zero                = zero_q;
   assign memory_out_of_bound = mob_q;
   assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: vector table through a 32-bit instance with a result
// scoreboard, plus hand sequences for start-while-busy, mid-op reset and WIDTH=8.
module tb_seq_alu;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic [3:0]  ALUop;
   logic [31:0] op1, op2;
   logic [4:0]  shamt;
   logic        busy, done, OVF, zero, mob;
   logic [31:0] result;
   logic [1:0]  dbg_state;

   logic        start8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8;
   logic [2:0]  sh8;
   logic        busy8, done8, ovf8, zero8, mob8;
   logic [7:0]  res8;
   logic [1:0]  dbg8;

   seq_alu #(.WIDTH(32), .MEM_LIMIT(255)) u_dut (
      .clk(clk), .rst(rst), .start(start), .ALUop(ALUop), .op1(op1), .op2(op2),
      .shamt(shamt), .busy(busy), .done(done), .result(result), .OVF(OVF),
      .zero(zero), .memory_out_of_bound(mob), .dbg_state_o(dbg_state)
   );

   seq_alu #(.WIDTH(8), .MEM_LIMIT(255)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .ALUop(op8), .op1(a8), .op2(b8),
      .shamt(sh8), .busy(busy8), .done(done8), .result(res8), .OVF(ovf8),
      .zero(zero8), .memory_out_of_bound(mob8), .dbg_state_o(dbg8)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        ovf;
      logic        mob;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   logic [2:0]  exp_flags_q[$];
   logic [31:0] mon_res;
   logic [2:0]  mon_flags;
   int          checks = 0;
   int          errors = 0;
   bit          release_pending = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] res, input logic ovf,
                          input logic m);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.ovf = ovf; v.mob = m;
      vecs.push_back(v);
   endtask

   // Scoreboard: every done pulse consumes one expected record.
   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending operation");
         end else begin
            mon_res   = exp_q.pop_front();
            mon_flags = exp_flags_q.pop_front();
            check("result", result, mon_res);
            check("ovf_zero_mob", {OVF, zero, mob}, mon_flags);
         end
      end
   end

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] er, input logic eovf,
                         input logic emob, input int poke);
      int cyc;
      int exp_lat;
      bit busy_ok;
      exp_lat = (op == 4'hA || op == 4'hB || op == 4'hC) ? 33 : 1;
      @(negedge clk);
      start = 1'b1; ALUop = op; op1 = a; op2 = b; shamt = sh;
      if (release_pending) begin
         rst = 1'b1;
         release_pending = 1'b0;
      end
      exp_q.push_back(er);
      exp_flags_q.push_back({eovf, (er == 32'd0), emob});
      @(negedge clk);
      start = 1'b0;
      op1   = $urandom();
      op2   = $urandom();
      shamt = 5'($urandom_range(0, 31));
      ALUop = 4'($urandom_range(0, 15));
      cyc = 1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (cyc == poke) begin
            start = 1'b1;
            ALUop = 4'h0;
         end
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      check("latency", cyc, exp_lat);
      check("busy_held", busy_ok, 1);
      @(negedge clk);
      check("idle_after_fin", {busy, done}, 0);
      check("result_hold", result, er);
   endtask

   task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sh, input logic [7:0] er, input logic eovf,
                       input logic emob, input int exp_lat);
      int cyc;
      @(negedge clk);
      start8 = 1'b1; op8 = op; a8 = a; b8 = b; sh8 = sh;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom());
      b8 = 8'($urandom());
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("w8_latency", cyc, exp_lat);
      check("w8_result", res8, er);
      check("w8_ovf_zero_mob", {ovf8, zero8, mob8}, {eovf, (er == 8'd0), emob});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      rst = 1'b0; start = 1'b0; ALUop = '0; op1 = '0; op2 = '0; shamt = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; sh8 = '0;

      add_vec(4'h0, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1'b1);
      add_vec(4'h0, 32'd200,      32'd55,       5'd0,  32'd255,      1'b0, 1'b0);
      add_vec(4'h0, 32'd200,      32'd56,       5'd0,  32'd256,      1'b0, 1'b1);
      add_vec(4'h0, 32'hFFFFFFFF, 32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b1);
      add_vec(4'h1, 32'd5,        32'd5,        5'd0,  32'h0,        1'b0, 1'b0);
      add_vec(4'h1, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1, 1'b1);
      add_vec(4'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 5'd0,  32'h80000000, 1'b0, 1'b1);
      add_vec(4'h2, 32'hC,        32'hA,        5'd0,  32'h8,        1'b0, 1'b0);
      add_vec(4'h3, 32'hC,        32'hA,        5'd0,  32'hE,        1'b0, 1'b0);
      add_vec(4'h4, 32'hC,        32'hA,        5'd0,  32'h6,        1'b0, 1'b0);
      add_vec(4'h5, 32'hC,        32'hA,        5'd0,  32'hFFFFFFF1, 1'b0, 1'b0);
      add_vec(4'h6, 32'hFFFFFFFB, 32'd3,        5'd0,  32'h1,        1'b0, 1'b1);
      add_vec(4'h6, 32'd3,        32'hFFFFFFFB, 5'd0,  32'h0,        1'b0, 1'b1);
      add_vec(4'h9, 32'd3,        32'hFFFFFFFB, 5'd0,  32'h1,        1'b0, 1'b1);
      add_vec(4'h9, 32'd4,        32'd4,        5'd0,  32'h0,        1'b0, 1'b0);
      add_vec(4'h7, 32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0);
      add_vec(4'h8, 32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b1);
      add_vec(4'hD, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b1);
      add_vec(4'hD, 32'h0,        32'h40000000, 5'd4,  32'h04000000, 1'b0, 1'b1);
      add_vec(4'hE, 32'd5,        32'd6,        5'd0,  32'h0,        1'b0, 1'b0);
      add_vec(4'hF, 32'd5,        32'd6,        5'd0,  32'h0,        1'b0, 1'b0);
      add_vec(4'hA, 32'h10000,    32'h10000,    5'd0,  32'h0,        1'b1, 1'b1);
      add_vec(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h1,        1'b0, 1'b1);
      add_vec(4'hA, 32'h7FFFFFFF, 32'd2,        5'd0,  32'hFFFFFFFE, 1'b1, 1'b1);
      add_vec(4'hA, 32'h80000000, 32'd1,        5'd0,  32'h80000000, 1'b0, 1'b1);
      add_vec(4'hB, 32'hFFFFFFF9, 32'd2,        5'd0,  32'hFFFFFFFD, 1'b0, 1'b1);
      add_vec(4'hC, 32'hFFFFFFF9, 32'd2,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b1);
      add_vec(4'hB, 32'd5,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b1, 1'b0);
      add_vec(4'hC, 32'd5,        32'd0,        5'd0,  32'd5,        1'b1, 1'b0);
      add_vec(4'hB, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b1);
      add_vec(4'hC, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 1'b1);
      add_vec(4'hB, 32'd100,      32'hFFFFFFF9, 5'd0,  32'hFFFFFFF2, 1'b0, 1'b0);
      add_vec(4'hC, 32'd100,      32'hFFFFFFF9, 5'd0,  32'd2,        1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("rst_busy_done", {busy, done, busy8, done8}, 0);
      check("rst_result", result, 0);
      check("rst_flags", {OVF, zero, mob}, 0);
      check("rst_state", {dbg_state, dbg8}, 0);
      check("rst_result8", {res8, ovf8, zero8, mob8}, 0);

      // First start coincides with reset release.
      release_pending = 1'b1;
      foreach (vecs[i])
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].res,
                vecs[i].ovf, vecs[i].mob, 0);

      // Multiply with a start pulse five cycles in, which must be ignored.
      run_op(4'hA, 32'hFFFFFFFD, 32'd7, 5'd0, 32'hFFFFFFEB, 1'b0, 1'b0, 5);

      // Reset ten cycles into a multiply.
      @(negedge clk);
      start = 1'b1; ALUop = 4'hA; op1 = 32'd1234; op2 = 32'd5678;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("busy_before_abort", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("abort_busy_done", {busy, done}, 0);
      check("abort_result", result, 0);
      check("abort_flags", {OVF, zero, mob}, 0);
      check("abort_state", dbg_state, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("no_done_after_abort", dones, 0);
      run_op(4'h1, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1'b0, 0);

      run8(4'hB, 8'h80, 8'hFF, 3'd0, 8'h80, 1'b1, 1'b1, 9);
      run8(4'hC, 8'h80, 8'hFF, 3'd0, 8'h00, 1'b1, 1'b1, 9);
      run8(4'hD, 8'h00, 8'h90, 3'd3, 8'hF2, 1'b0, 1'b1, 1);
      run8(4'hA, 8'h10, 8'h10, 3'd0, 8'h00, 1'b1, 1'b0, 9);
      run8(4'hA, 8'hFD, 8'h07, 3'd0, 8'hEB, 1'b0, 1'b0, 9);
      run8(4'h0, 8'h7F, 8'h01, 3'd0, 8'h80, 1'b1, 1'b0, 1);

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
